// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction loader.
// Receives a byte stream made of a 4-byte little-endian word count N followed by
// N little-endian 32-bit words. Each word is written to instruction memory at
// byte address 4*k. The module then reports done, or reports error when N does
// not fit in the memory.
module inst_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word counter is one bit wider than a word index, so that N == CAP fits.
    localparam int          CNT_W = ADDR_W - 1;
    localparam logic [32:0] CAP   = 33'd1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_cnt;    // position of the next byte within its 4-byte group
    logic [31:0]        header;      // shifts in header bytes, then holds N
    logic [23:0]        word_buf;    // first three bytes of the word being assembled
    logic [CNT_W-1:0]   word_cnt;    // words written so far (k)

    logic               byte_last;
    logic [31:0]        hdr_full;
    logic [31:0]        word_full;
    logic               last_word;

    // Byte-group decode: whole header or whole word as seen with the current byte
    always_comb begin
        byte_last = (byte_cnt == 2'd3);
        hdr_full  = {rx_data, header[31:8]};
        word_full = {rx_data, word_buf};
        last_word = ((word_cnt + CNT_W'(1)) == header[CNT_W-1:0]);
    end

    // Next-state logic: header classification, then count words down to DONE
    always_comb begin
        // NOTE: state_next gets a default before the case so that no path leaves it unassigned, which would infer a latch.
        state_next = state;
        case (state)
            S_LEN: begin
                if (rx_valid && byte_last) begin
                    if (hdr_full == 32'd0) begin
                        state_next = S_DONE;
                    end else if ({1'b0, hdr_full} > CAP) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid && byte_last && last_word) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = state;   // DONE and ERR hold until reset
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_LEN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    // Datapath: header/word assembly and the registered memory write port
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is cleared on reset; a partial header or word must never survive into the next image.
        if (!reset_n) begin
            byte_cnt <= 2'd0;
            header   <= 32'd0;
            word_buf <= 24'd0;
            word_cnt <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= 32'd0;
        end else begin
            we <= 1'b0;
            case (state)
                S_LEN: begin
                    if (rx_valid) begin
                        header   <= hdr_full;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        word_buf <= word_full[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_last) begin
                            we       <= 1'b1;
                            wdata    <= word_full;
                            waddr    <= {word_cnt[CNT_W-2:0], 2'b00};
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    we <= 1'b0;
                end
            endcase
        end
    end

    // Status flags follow directly from the state and header progress
    always_comb begin
        done  = (state == S_DONE);
        error = (state == S_ERR);
        busy  = (state == S_DATA) || ((state == S_LEN) && (byte_cnt != 2'd0));
    end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: a directed vector table, hand-written reset
// sequences, and randomized streams checked against a behavioural model.
// A second instance with ADDR_W=4 covers the CAP boundary.
module tb_inst_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ADDR_W = 15 (CAP = 8192)
    logic        reset_n_a, rx_valid_a;
    logic [7:0]  rx_data_a;
    logic        we_a, busy_a, done_a, error_a;
    logic [14:0] waddr_a;
    logic [31:0] wdata_a;

    // Instance B: ADDR_W = 4 (CAP = 4)
    logic        reset_n_b, rx_valid_b;
    logic [7:0]  rx_data_b;
    logic        we_b, busy_b, done_b, error_b;
    logic [3:0]  waddr_b;
    logic [31:0] wdata_b;

    inst_loader #(.ADDR_W(15)) dut_a (
        .clk(clk), .reset_n(reset_n_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    inst_loader #(.ADDR_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    typedef struct packed {
        logic [95:0] bytes;     // byte i at bits [8*i +: 8]
        logic [7:0]  nb;
        logic [7:0]  exp_we;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        exp_done;
        logic        exp_err;
        logic        exp_busy;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    bit          started  = 1'b0;
    int          target   = 0;      // 0 drives instance A, 1 drives instance B
    wr_t         wq_a[$];
    wr_t         wq_b[$];
    wr_t         exp_q[$];
    logic [7:0]  bq[$];             // byte stream under test

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor plus the done/error exclusivity check, sampled mid-cycle
    always @(negedge clk) begin
        wr_t w;
        if (started) begin
            if (we_a === 1'b1) begin
                w.addr = 32'(waddr_a); w.data = wdata_a; w.done = done_a;
                wq_a.push_back(w);
            end
            if (we_b === 1'b1) begin
                w.addr = 32'(waddr_b); w.data = wdata_b; w.done = done_b;
                wq_b.push_back(w);
            end
            check("done_and_error_a", {31'd0, done_a & error_a}, 32'd0);
            check("done_and_error_b", {31'd0, done_b & error_b}, 32'd0);
        end
    end

    function automatic logic [31:0] g_out(input int sel);
        case (sel)
            0: return (target == 0) ? {31'd0, we_a}    : {31'd0, we_b};
            1: return (target == 0) ? 32'(waddr_a)     : 32'(waddr_b);
            2: return (target == 0) ? wdata_a          : wdata_b;
            3: return (target == 0) ? {31'd0, busy_a}  : {31'd0, busy_b};
            4: return (target == 0) ? {31'd0, done_a}  : {31'd0, done_b};
            default: return (target == 0) ? {31'd0, error_a} : {31'd0, error_b};
        endcase
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit rn);
        if (target == 0) begin
            rx_valid_a = v; rx_data_a = d; reset_n_a = rn;
        end else begin
            rx_valid_b = v; rx_data_b = d; reset_n_b = rn;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        drive(1'b1, d, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b1);
    endtask

    // One-cycle reset with a valid byte present, which must be ignored
    task automatic do_reset();
        drive(1'b1, 8'h01, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic clear_writes();
        if (target == 0) wq_a.delete(); else wq_b.delete();
    endtask

    task automatic play(input int maxgap);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            idle($urandom_range(0, maxgap));
        end
        idle(2);
    endtask

    // Reference model: derives the expected writes and final flags from the stream
    task automatic model(input int aw, output bit e_done, output bit e_err, output bit e_busy);
        longint n;
        longint cap;
        int     nfull;
        wr_t    w;
        exp_q.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        e_busy = (bq.size() > 0);
        if (bq.size() >= 4) begin
            n   = longint'({bq[3], bq[2], bq[1], bq[0]});
            cap = longint'(1) << (aw - 2);
            if (n == 0) begin
                e_done = 1'b1; e_busy = 1'b0;
            end else if (n > cap) begin
                e_err = 1'b1; e_busy = 1'b0;
            end else begin
                nfull = (bq.size() - 4) / 4;
                if (longint'(nfull) >= n) nfull = int'(n);
                for (int k = 0; k < nfull; k++) begin
                    w.addr = 32'(4 * k);
                    w.data = {bq[4+4*k+3], bq[4+4*k+2], bq[4+4*k+1], bq[4+4*k]};
                    w.done = (longint'(k) == n - 1);
                    exp_q.push_back(w);
                end
                if (longint'(nfull) == n) begin
                    e_done = 1'b1; e_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_run(input string tag, input bit e_done, input bit e_err, input bit e_busy);
        wr_t act_q[$];
        act_q = (target == 0) ? wq_a : wq_b;
        check({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), act_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_data%0d", tag, i), act_q[i].data, exp_q[i].data);
            check($sformatf("%s_wdone%0d", tag, i), {31'd0, act_q[i].done}, {31'd0, exp_q[i].done});
        end
        @(negedge clk);
        check({tag, "_done"},  g_out(4), {31'd0, e_done});
        check({tag, "_error"}, g_out(5), {31'd0, e_err});
        check({tag, "_busy"},  g_out(3), {31'd0, e_busy});
        @(posedge clk); #1;
    endtask

    vec_t vecs [0:6];

    initial begin
        bit   ed, ee, eb;
        wr_t  w;
        int   n;
        int   extra;

        reset_n_a = 1'b0; rx_valid_a = 1'b0; rx_data_a = 8'h00;
        reset_n_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;

        // Directed vectors on instance A; the byte images read naturally as little-endian words
        vecs[0] = '{bytes: 96'h00100093_00000013_00000002, nb: 8'd12, exp_we: 8'd2,
                    d0: 32'h00000013, d1: 32'h00100093, exp_done: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{bytes: 96'h0, nb: 8'd4, exp_we: 8'd0,
                    d0: 32'h0, d1: 32'h0, exp_done: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        vecs[2] = '{bytes: 96'h44332211_00002001, nb: 8'd8, exp_we: 8'd0,
                    d0: 32'h0, d1: 32'h0, exp_done: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{bytes: 96'hAABBCCDD_01000001, nb: 8'd8, exp_we: 8'd0,
                    d0: 32'h0, d1: 32'h0, exp_done: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[4] = '{bytes: 96'hDEADBEEF_00000001, nb: 8'd8, exp_we: 8'd1,
                    d0: 32'hDEADBEEF, d1: 32'h0, exp_done: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
        vecs[5] = '{bytes: 96'h00CCBBAA_12345678_00000002, nb: 8'd11, exp_we: 8'd1,
                    d0: 32'h12345678, d1: 32'h0, exp_done: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[6] = '{bytes: 96'h00002000, nb: 8'd4, exp_we: 8'd0,
                    d0: 32'h0, d1: 32'h0, exp_done: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};

        target = 0;
        for (int v = 0; v < 7; v++) begin
            do_reset();
            clear_writes();
            bq.delete();
            for (int j = 0; j < int'(vecs[v].nb); j++) bq.push_back(vecs[v].bytes[8*j +: 8]);
            play(0);
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].exp_we); i++) begin
                w.addr = 32'(4 * i);
                w.data = (i == 0) ? vecs[v].d0 : vecs[v].d1;
                w.done = vecs[v].exp_done && (i == int'(vecs[v].exp_we) - 1);
                exp_q.push_back(w);
            end
            compare_run($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_busy);
        end

        // Reset after a completed image clears every output; busy rises on the first header byte
        do_reset();
        clear_writes();
        bq.delete();
        for (int j = 0; j < 12; j++) bq.push_back(vecs[0].bytes[8*j +: 8]);
        play(0);
        do_reset();
        @(negedge clk);
        check("rst_we",    g_out(0), 32'd0);
        check("rst_waddr", g_out(1), 32'd0);
        check("rst_wdata", g_out(2), 32'd0);
        check("rst_busy",  g_out(3), 32'd0);
        check("rst_done",  g_out(4), 32'd0);
        check("rst_error", g_out(5), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h02);
        @(negedge clk);
        check("busy_first_byte", g_out(3), 32'd1);
        @(posedge clk); #1;

        // Reset mid-word discards the partial word and restarts at header byte 0
        do_reset();
        clear_writes();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        play(0);
        model(15, ed, ee, eb);
        compare_run("midword_reset", ed, ee, eb);

        // Reset mid-header discards the partial header
        do_reset();
        clear_writes();
        send_byte(8'h05); send_byte(8'h00);
        do_reset();
        bq = '{8'h00, 8'h00, 8'h00, 8'h00};
        play(0);
        model(15, ed, ee, eb);
        compare_run("midhdr_reset", ed, ee, eb);

        // N=3 with idle gaps of 0-5 cycles, then trailing bytes that must be ignored
        do_reset();
        clear_writes();
        bq = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 12 + 5; j++) bq.push_back(8'($urandom));
        play(5);
        model(15, ed, ee, eb);
        compare_run("gaps_n3", ed, ee, eb);

        // Randomized streams: small N, zero, oversize, truncated, with trailing bytes
        for (int it = 0; it < 25; it++) begin
            do_reset();
            clear_writes();
            bq.delete();
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = 8193 + int'($urandom_range(0, 1000));
                2:       n = int'($urandom | 32'h0001_0000);
                default: n = int'($urandom_range(1, 5));
            endcase
            for (int j = 0; j < 4; j++) bq.push_back(8'(n >> (8 * j)));
            if (n > 0 && n <= 5) begin
                extra = 4 * n + int'($urandom_range(0, 6));
                if ($urandom_range(0, 4) == 0) extra = extra - int'($urandom_range(1, 3));
            end else begin
                extra = int'($urandom_range(0, 6));
            end
            for (int j = 0; j < extra; j++) bq.push_back(8'($urandom));
            play(int'($urandom_range(0, 3)));
            model(15, ed, ee, eb);
            compare_run($sformatf("rand%0d", it), ed, ee, eb);
        end

        // Capacity boundary on the ADDR_W=4 instance: N=CAP is legal, N=CAP+1 is not
        target = 1;
        do_reset();
        clear_writes();
        bq = '{8'h04, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 16; j++) bq.push_back(8'($urandom));
        play(0);
        model(4, ed, ee, eb);
        compare_run("cap_n4", ed, ee, eb);
        if (wq_b.size() == 4) check("cap_last_addr", wq_b[3].addr, 32'hC);

        do_reset();
        clear_writes();
        bq = '{8'h05, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 8; j++) bq.push_back(8'($urandom));
        play(0);
        model(4, ed, ee, eb);
        compare_run("cap_n5", ed, ee, eb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 15, meaning the byte-address width of instruction memory; capacity CAP = 2^(ADDR_W-2) words.
REQ-002 The module SHALL have port clk, input, 1, system clock; all logic rising-edge.
REQ-003 The module SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-004 The module SHALL have port rx_valid, input, 1, one-cycle strobe marking a received byte.
REQ-005 The module SHALL have port rx_data, input, 8, byte qualified by rx_valid.
REQ-006 The module SHALL have port we, output, 1, instruction-memory write enable, one-cycle pulse per word.
REQ-007 The module SHALL have port waddr, output, ADDR_W, byte address of the word being written; bits [1:0] always 0.
REQ-008 The module SHALL have port wdata, output, 32, word being written.
REQ-009 The module SHALL have port busy, output, 1, high from the first accepted byte until DONE or ERR.
REQ-010 The module SHALL have port done, output, 1, image fully written; CPU may leave reset.
REQ-011 The module SHALL have port error, output, 1, header word count exceeds CAP.

Function
REQ-012 The module SHALL accept a byte stream of a 4-byte little-endian header N (word count), then N words, each 4 bytes little-endian.
REQ-013 The module SHALL implement states LEN, DATA, DONE, ERR; after reset the state SHALL be LEN.
REQ-014 In LEN, the module SHALL shift each rx_valid byte into the header; on the 4th byte: N=0 -> DONE, N>CAP -> ERR, else -> DATA.
REQ-015 In DATA, the module SHALL assemble bytes into wdata, first byte into [7:0], fourth into [31:24].
REQ-016 On the clock edge sampling a word's 4th byte, the module SHALL register we=1, wdata=assembled word, waddr=4*k for the k-th word (k from 0), so we is high exactly the following cycle.
REQ-017 waddr and wdata SHALL hold their values after the we pulse until the next write.
REQ-018 On the edge sampling the 4th byte of word N-1, the module SHALL set done=1 and enter DONE, with done high in the same cycle as the final we.
REQ-019 The module SHALL accept rx_valid on every cycle, back-to-back, with no stall and no byte loss.
REQ-020 In DONE and ERR, the module SHALL ignore rx_valid, keep we=0, and stay there until reset.
REQ-021 The module SHALL never assert done and error simultaneously.
REQ-022 busy SHALL be 0 in DONE and ERR, and 1 in LEN after at least one header byte and throughout DATA.
REQ-023 The word counter SHALL be ADDR_W-1 bits wide so that N=CAP is representable, and N=CAP SHALL be legal, with the last waddr = 4*(CAP-1).
REQ-024 The header comparison SHALL use all 32 bits of N, so that any nonzero upper bits beyond CAP yield ERR.

Reset
REQ-025 When reset_n=0 at a rising edge, the module SHALL force: state LEN, byte and word counters 0, header 0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0.
REQ-026 Reset asserted mid-header or mid-word SHALL discard partial data with no write, and the next byte after release SHALL be header byte 0.
REQ-027 rx_valid sampled in the same cycle as reset_n=0 SHALL be ignored.

Verification
REQ-028 Bytes 02 00 00 00 13 00 00 00 93 00 10 00, back-to-back -> we pulses: (waddr 0x0, wdata 0x00000013), (0x4, 0x00100093); done=1 with the 2nd pulse; busy=0 thereafter.
REQ-029 Header 00 00 00 00 -> no we, done=1 the cycle after the 4th byte, error=0.
REQ-030 With ADDR_W=15, header 01 20 00 00 (N=8193) -> error=1, done=0, and subsequent bytes produce no we.
REQ-031 Header N=1, then bytes AA BB with reset_n=0 for 1 cycle, then 01 00 00 00 EF BE AD DE -> single we: waddr 0x0, wdata 0xDEADBEEF.
REQ-032 N=3 with random idle gaps of 0-5 cycles between bytes -> 3 writes at 0x0, 0x4, 0x8 with correct data; extra bytes after done -> no we.
REQ-033 With ADDR_W=4 (CAP=4), header N=4 followed by 16 bytes -> 4 writes, last waddr 0xC, done=1; header N=5 -> error=1.
